// File: rtl/apb_master.sv
// APB master: turns a valid/ready command into one APB transfer and returns a one-cycle response.
// Optional ACCESS timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned addrWidth      = 32,
  parameter int unsigned dataWidth      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e               state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [addrWidth-1:0] paddr_q, paddr_d;
  logic [dataWidth-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = StSetup;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      StAccess: begin
        if (pready) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Give up: the responder never answered within the budget.
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      default: begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: timestamp-based transaction model checked every cycle, plus literal
// checks for timing, read-back, back-to-back spacing, timeout and mid-transfer reset.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_err, pwrite, psel, penable;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic          pready = 1'b0;

  apb_master #(.addrWidth(AW), .dataWidth(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0, n_fail = 0;
  int negcnt = 0, rspcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: word memory, pready mode 0=random, 1=one wait state, 2=never.
  logic [31:0] mem [256];
  int mode = 1;
  int pen_seen = 0;
  assign prdata = mem[paddr[9:2]];

  initial begin
    forever begin
      @(negedge pclk);
      if (penable) pen_seen++;
      else pen_seen = 0;
      case (mode)
        0:       pready = ($urandom_range(0, 2) == 0);
        1:       pready = (pen_seen >= 2);
        default: pready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge pclk);
      if (!rst && psel && penable && pready && pwrite) mem[paddr[9:2]] = pwdata;
    end
  end

  // Model: a transfer accepted at edge A holds psel until the first edge >= A+2 sampling
  // pready (or edge A+1+TO on timeout); penable is high from edge A+1 on.
  bit            m_busy = 0, m_write = 0;
  int            m_acc = 0, cyc = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, e_rdata = '0;
  bit            e_ready = 1, e_psel = 0, e_pen = 0, e_rv = 0, e_err = 0;

  initial begin
    forever begin
      @(posedge pclk or posedge rst);
      if (rst) begin
        m_busy = 0; m_write = 0; m_addr = '0; m_wdata = '0; e_rdata = '0;
        e_rv = 0; e_err = 0;
      end else begin
        e_rv = 0; e_err = 0;
        if (!m_busy) begin
          if (cmd_valid) begin
            m_busy = 1; m_acc = cyc; m_write = cmd_write; m_addr = cmd_addr;
            m_wdata = cmd_wdata;
          end
        end else if (cyc >= m_acc + 2 && pready) begin
          m_busy = 0; e_rv = 1; e_rdata = m_write ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (cyc == m_acc + 1 + TO) begin
          m_busy = 0; e_rv = 1; e_err = 1; e_rdata = '0;
`endif
        end
        cyc++;
      end
      e_ready = !m_busy;
      e_psel  = m_busy;
      e_pen   = m_busy && (cyc > m_acc + 1);
    end
  end

  initial begin
    forever begin
      @(negedge pclk);
      negcnt++;
      if (rsp_valid) rspcnt++;
      if (!rst) begin
        check("cmd_ready", cmd_ready, e_ready);
        check("psel", psel, e_psel);
        check("penable", penable, e_pen);
        check("pwrite", pwrite, m_write);
        check("paddr", paddr, m_addr);
        check("pwdata", pwdata, m_wdata);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_err", rsp_err, e_err);
        check("rsp_rdata", rsp_rdata, e_rdata);
      end
    end
  end

  // Returns just after the acceptance edge; leaves cmd_valid high when hold is set.
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit hold);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk); #1; n++;
    end
    check("send_ready_wait", cmd_ready, 1);
    @(posedge pclk); #1;
    cmd_valid = hold;
  endtask

  task automatic wait_rsp(input int bound);
    int n = 0;
    do begin
      @(negedge pclk); #1; n++;
    end while (!rsp_valid && n < bound);
    check("rsp_wait", rsp_valid, 1);
  endtask

  logic [4:0] ps_v, rv_v;
  int t0, r0, pc;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge pclk);
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge pclk); #1;

    // Single write with one-wait responder: psel three cycles, response in the fourth.
    mode = 1;
    send(1, 32'h10, 32'hA5A5_5A5A, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk); #1;
      ps_v[i] = psel;
      rv_v[i] = rsp_valid;
    end
    check("timing_psel", ps_v, 5'b00111);
    check("timing_rsp", rv_v, 5'b01000);

    send(0, 32'h10, '0, 0);
    wait_rsp(50);
    check("rd_0x10", rsp_rdata, 32'hA5A5_5A5A);
    send(0, 32'h20, '0, 0);
    wait_rsp(50);
    check("rd_0x20", rsp_rdata, 32'h0);

    // Three commands with cmd_valid held: four-cycle period, one idle cycle between.
    send(1, 32'h40, 32'h1111, 1);
    t0 = negcnt; r0 = rspcnt;
    send(1, 32'h44, 32'h2222, 1);
    send(0, 32'h40, '0, 0);
    wait_rsp(40);
    check("b2b_cycles", negcnt - t0, 12);
    check("b2b_rsp_count", rspcnt - r0, 3);
    check("b2b_rdata", rsp_rdata, 32'h1111);

    mode = 0;
    for (int i = 0; i < 80; i++) begin
      bit hold;
      hold = ($urandom_range(0, 3) == 0);
      send(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge pclk);
    end
    cmd_valid = 1'b0;
    wait_rsp(200);

    // Responder that never answers.
    @(negedge pclk); #1;
    mode = 2;
    send(0, 32'h80, '0, 0);
    pc = 0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int n = 0; n < 60; n++) begin
      @(negedge pclk); #1;
      if (penable) pc++;
      if (rsp_valid) break;
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_access_cycles", pc, TO);
    send(1, 32'h84, 32'h5555, 0);
`else
    repeat (110) begin
      @(negedge pclk); #1;
      if (psel) pc++;
    end
    check("hang_psel_cycles", pc, 110);
`endif

    // Reset in the middle of ACCESS.
    pc = 0;
    while (!penable && pc < 20) begin
      @(negedge pclk); #1; pc++;
    end
    check("rst_test_in_access", penable, 1);
    @(posedge pclk); #3;
    rst = 1'b1;
    #1;
    check("async_psel", psel, 0);
    check("async_penable", penable, 0);
    check("async_rsp_valid", rsp_valid, 0);
    @(negedge pclk); #1;
    rst = 1'b0;
    check("post_rst_ready", cmd_ready, 1);
    pc = 0;
    repeat (4) begin
      @(negedge pclk); #1;
      if (rsp_valid) pc++;
    end
    check("post_rst_no_rsp", pc, 0);

    mode = 1;
    send(1, 32'h30, 32'hDEAD_BEEF, 0);
    wait_rsp(20);
    check("final_wr_err", rsp_err, 0);
    send(0, 32'h30, '0, 0);
    wait_rsp(20);
    check("final_rd", rsp_rdata, 32'hDEAD_BEEF);

    repeat (2) @(negedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
